bit_grouper: RTL and testbench

BIT_GROUPER -- requirements
Module: bit_grouper

---
 rtl/bit_grouper.sv | 72 +++++++
 tb/tb_bit_grouper.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_grouper.sv
// bit_grouper: packs serial bits into N_BPSC-bit mapper groups, tagging each with its subcarrier index
module bit_grouper #(
    parameter int N_SC = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mod,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [5:0] out_x,
    output logic [1:0] out_mod,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] out_sc_idx,
    output logic       out_sym_last
);
    localparam logic [5:0] SC_LAST = 6'(N_SC - 1);
    logic [1:0] mod_q;
    logic [5:0] acc;
    logic [2:0] bcnt;
    logic [5:0] sc;
    logic       first;
    logic       last;
    logic       accept;
    logic [1:0] cur_mod;
    logic [2:0] top;
    logic [5:0] mask;
    logic [5:0] grp;
    always_comb begin
        first    = bcnt == 3'd0 && sc == 6'd0;
        cur_mod  = first ? mod : mod_q;
        top      = cur_mod == 2'd0 ? 3'd0 : cur_mod == 2'd1 ? 3'd1 : cur_mod == 2'd2 ? 3'd3 : 3'd5;
        mask     = cur_mod == 2'd0 ? 6'h01 : cur_mod == 2'd1 ? 6'h03 : cur_mod == 2'd2 ? 6'h0f : 6'h3f;
        last     = bcnt == top;
        in_ready = !rst && (!last || !out_valid || out_ready);
        accept   = in_valid && in_ready;
        grp      = acc;
        grp[bcnt] = in_bit;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            mod_q        <= '0;
            acc          <= '0;
            bcnt         <= '0;
            sc           <= '0;
            out_x        <= '0;
            out_mod      <= '0;
            out_sc_idx   <= '0;
            out_sym_last <= 1'b0;
            out_valid    <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (accept) begin
                if (first) mod_q <= mod;
                if (last) begin
                    out_x        <= grp & mask;
                    out_mod      <= cur_mod;
                    out_sc_idx   <= sc;
                    out_sym_last <= sc == SC_LAST;
                    out_valid    <= 1'b1;
                    acc          <= '0;
                    bcnt         <= '0;
                    sc           <= sc == SC_LAST ? 6'd0 : sc + 6'd1;
                end else begin
                    acc  <= grp;
                    bcnt <= bcnt + 3'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_bit_grouper.sv
// tb_bit_grouper: directed and randomized checks of bit_grouper against a symbol-level grouping model
module tb_bit_grouper;
    localparam int N_SC = 48;
    typedef struct {
        logic [5:0] x;
        logic [1:0] m;
        logic [5:0] idx;
        logic       last;
    } grp_t;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mod = 2'd0;
    logic       in_bit = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] out_x;
    logic [1:0] out_mod;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [5:0] out_sc_idx;
    logic       out_sym_last;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   rand_rdy = 1'b0;
    grp_t exp_q[$];
    int   xcyc[$];
    bit   held = 1'b0;
    grp_t hv;

    bit_grouper #(.N_SC(N_SC)) dut (
        .clk(clk), .rst(rst), .mod(mod), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(in_ready), .out_x(out_x), .out_mod(out_mod), .out_valid(out_valid),
        .out_ready(out_ready), .out_sc_idx(out_sc_idx), .out_sym_last(out_sym_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) if (rand_rdy) begin
        #1;
        out_ready = $urandom_range(0, 2) != 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int nb(input logic [1:0] m);
        return m == 2'd0 ? 1 : m == 2'd1 ? 2 : m == 2'd2 ? 4 : 6;
    endfunction

    task automatic expect_grp(input logic [5:0] x, input logic [1:0] m, input int g);
        grp_t e;
        e.x = x;
        e.m = m;
        e.idx = 6'(g);
        e.last = g == N_SC - 1;
        exp_q.push_back(e);
    endtask

    // Returns one phase after the accepting edge with in_valid dropped.
    task automatic send_bit(input logic b, input logic [1:0] m);
        in_bit = b;
        mod = m;
        in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("in_timeout", 32'(in_ready), 1);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic run_symbol(input logic [1:0] m, input logic [1:0] m_late, input bit noisy);
        for (int g = 0; g < N_SC; g++) begin
            logic [5:0] x;
            x = 6'($urandom) & 6'((1 << nb(m)) - 1);
            expect_grp(x, m, g);
            for (int i = 0; i < nb(m); i++) begin
                if (noisy && $urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                send_bit(x[i], (g == 0 && i == 0) ? m : noisy ? 2'($urandom) : g >= 10 ? m_late : m);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) held = 1'b0;
        else begin
            if (held) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_x", 32'(out_x), 32'(hv.x));
                check("hold_mod", 32'(out_mod), 32'(hv.m));
                check("hold_idx", 32'(out_sc_idx), 32'(hv.idx));
                check("hold_last", 32'(out_sym_last), 32'(hv.last));
            end
            if (out_valid && out_ready) begin
                xcyc.push_back(cyc);
                if (exp_q.size() == 0) check("extra_group", 32'(out_valid), 0);
                else begin
                    grp_t e;
                    e = exp_q.pop_front();
                    check("grp_x", 32'(out_x), 32'(e.x));
                    check("grp_mod", 32'(out_mod), 32'(e.m));
                    check("grp_idx", 32'(out_sc_idx), 32'(e.idx));
                    check("grp_last", 32'(out_sym_last), 32'(e.last));
                end
            end
            held = out_valid && !out_ready;
            hv.x = out_x;
            hv.m = out_mod;
            hv.idx = out_sc_idx;
            hv.last = out_sym_last;
        end
    end

    initial begin
        logic [5:0] g0;
        logic [5:0] g1;
        int base;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_valid", 32'(out_valid), 0);
        check("reset_in_ready", 32'(in_ready), 0);
        check("reset_x", 32'(out_x), 0);
        check("reset_mod", 32'(out_mod), 0);
        check("reset_idx", 32'(out_sc_idx), 0);
        check("reset_last", 32'(out_sym_last), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        out_ready = 1'b1;
        g0 = 6'b001101;
        expect_grp(g0, 2'd3, 0);
        for (int i = 0; i < 6; i++) send_bit(g0[i], 2'd3);
        check("q64_valid", 32'(out_valid), 1);
        check("q64_x", 32'(out_x), 32'h0d);
        check("q64_mod", 32'(out_mod), 3);
        check("q64_idx", 32'(out_sc_idx), 0);
        @(posedge clk);
        #1;
        check("q64_one_cycle", 32'(out_valid), 0);

        do_reset();
        base = xcyc.size();
        run_symbol(2'd0, 2'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("bpsk_count", 32'(xcyc.size() - base), 48);
        check("bpsk_span", 32'(xcyc[xcyc.size() - 1] - xcyc[base]), 47);

        do_reset();
        out_ready = 1'b0;
        g0 = 6'($urandom) & 6'h0f;
        g1 = 6'($urandom) & 6'h0f;
        expect_grp(g0, 2'd2, 0);
        expect_grp(g1, 2'd2, 1);
        for (int i = 0; i < 4; i++) send_bit(g0[i], 2'd2);
        for (int i = 0; i < 3; i++) send_bit(g1[i], 2'd2);
        check("qam16_hold_x", 32'(out_x), 32'(g0));
        in_bit = g1[3];
        in_valid = 1'b1;
        @(negedge clk);
        check("qam16_ready_low", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("qam16_ready_high", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("qam16_valid_kept", 32'(out_valid), 1);
        check("qam16_x1", 32'(out_x), 32'(g1));
        check("qam16_idx1", 32'(out_sc_idx), 1);
        @(posedge clk);
        #1;

        do_reset();
        run_symbol(2'd1, 2'd3, 1'b0);
        run_symbol(2'd3, 2'd1, 1'b0);
        @(posedge clk);
        #1;
        check("modswitch_drained", 32'(exp_q.size()), 0);

        do_reset();
        g0 = 6'($urandom) & 6'h0f;
        expect_grp(g0, 2'd2, 0);
        for (int i = 0; i < 4; i++) send_bit(g0[i], 2'd2);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 2'd2);
        @(posedge clk);
        #1;
        do_reset();
        expect_grp(6'd0, 2'd2, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 2'd2);
        check("rst_mid_x", 32'(out_x), 0);
        check("rst_mid_idx", 32'(out_sc_idx), 0);
        @(posedge clk);
        #1;

        do_reset();
        rand_rdy = 1'b1;
        for (int s = 0; s < 3; s++) run_symbol(2'($urandom), 2'd0, 1'b1);
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        check("lost_groups", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
